// File: rtl/bp_update_ctrl_if.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl_if
// Bundles the signals between the branch-predictor update controller and its
// neighbours: fetch-stage lookup, execute-stage result handshake, the
// per-entry update bus to the predictor demultiplexer, flush control and the
// miss counter.
//   master : execute/fetch side (drives lookup, results, flush request)
//   slave  : bp_update_ctrl (drives prediction, ready, update bus, status)
// ---------------------------------------------------------------------------
interface bp_update_ctrl_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
);
    logic [IDX_W-1:0] lookup_addr;
    logic             predict;
    logic             res_valid;
    logic [IDX_W-1:0] res_addr;
    logic             res_outcome;
    logic             res_miss;
    logic             res_ready;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_addr;
    logic             upd_outcome;
    logic             upd_miss;
    logic             flush_req;
    logic             flush_busy;
    logic             flush_done;
    logic [CNT_W-1:0] miss_count;

    modport master (
        output lookup_addr, res_valid, res_addr, res_outcome, res_miss, flush_req,
        input  predict, res_ready, upd_valid, upd_addr, upd_outcome, upd_miss,
               flush_busy, flush_done, miss_count
    );

    modport slave (
        input  lookup_addr, res_valid, res_addr, res_outcome, res_miss, flush_req,
        output predict, res_ready, upd_valid, upd_addr, upd_outcome, upd_miss,
               flush_busy, flush_done, miss_count
    );
endinterface

// File: rtl/bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// bp_update_ctrl
// Sequencing controller for a 1-bit branch predictor. Resolved branches are
// accepted into a 2-entry FIFO and drained one per cycle into a 1-bit
// prediction table; every drained entry is also announced on the registered
// update bus. Queued mispredictions are bypassed to the fetch lookup. A flush
// request clears the table one entry per cycle once the queue has drained.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-low reset
//   bus   : bp_update_ctrl_if.slave (lookup/predict, result handshake,
//           update bus, flush request/busy/done, saturating miss counter)
// ---------------------------------------------------------------------------
module bp_update_ctrl #(
    parameter int IDX_W  = 3,
    parameter int QDEPTH = 2,
    parameter int CNT_W  = 16
) (
    input logic             clk,
    input logic             reset,
    bp_update_ctrl_if.slave bus
);
    localparam int         ENTRIES = 2 ** IDX_W;
    localparam logic [1:0] QMAX    = 2'(QDEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         count;
    logic [1:0]         count_nxt;
    logic [IDX_W-1:0]   q_addr [2];
    logic               q_out  [2];
    logic               q_miss [2];
    logic               flush_pend;
    logic [IDX_W-1:0]   idx;
    logic [ENTRIES-1:0] tbl;
    logic               upd_valid_r;
    logic [IDX_W-1:0]   upd_addr_r;
    logic               upd_outcome_r;
    logic               upd_miss_r;
    logic               flush_done_r;
    logic [CNT_W-1:0]   miss_count_r;
    logic               ready_c;
    logic               push;
    logic               pop;
    logic               wr_slot;
    logic               predict_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Ready is a function of registered state only, so a pop in the same
    // cycle cannot open the queue for a push.
    assign ready_c = (count < QMAX) && (state != FLUSH) && !flush_pend;
    assign push    = bus.res_valid && ready_c;
    assign pop     = (state == DRAIN) && (count != 2'd0);
    // A push lands behind the surviving entry; ready guarantees count<2 here.
    assign wr_slot = count[0] && !pop;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 2'd1;
        end else if (pop && !push) begin
            count_nxt = count - 2'd1;
        end
    end

    // Youngest matching misprediction wins, then the table.
    always_comb begin
        predict_c = tbl[bus.lookup_addr];
        if ((count != 2'd0) && q_miss[0] && (q_addr[0] == bus.lookup_addr)) begin
            predict_c = q_out[0];
        end
        if ((count == 2'd2) && q_miss[1] && (q_addr[1] == bus.lookup_addr)) begin
            predict_c = q_out[1];
        end
    end

    // Queue payload: no reset needed, validity is carried by count.
    always_ff @(posedge clk) begin
        if (pop) begin
            q_addr[0] <= q_addr[1];
            q_out[0]  <= q_out[1];
            q_miss[0] <= q_miss[1];
        end
        if (push) begin
            q_addr[wr_slot] <= bus.res_addr;
            q_out[wr_slot]  <= bus.res_outcome;
            q_miss[wr_slot] <= bus.res_miss;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= 2'd0;
            flush_pend    <= 1'b0;
            idx           <= '0;
            tbl           <= '0;
            upd_valid_r   <= 1'b0;
            upd_addr_r    <= '0;
            upd_outcome_r <= 1'b0;
            upd_miss_r    <= 1'b0;
            flush_done_r  <= 1'b0;
            miss_count_r  <= '0;
        end else begin
            count        <= count_nxt;
            upd_valid_r  <= 1'b0;
            flush_done_r <= 1'b0;
            if (push && bus.res_miss) begin
                miss_count_r <= sat_inc(miss_count_r);
            end
            if (bus.flush_req && (state != FLUSH)) begin
                flush_pend <= 1'b1;
            end
            if (pop) begin
                upd_valid_r   <= 1'b1;
                upd_addr_r    <= q_addr[0];
                upd_outcome_r <= q_out[0];
                upd_miss_r    <= q_miss[0];
                if (q_miss[0]) begin
                    tbl[q_addr[0]] <= q_out[0];
                end
            end
            case (state)
                IDLE: begin
                    if (flush_pend) begin
                        state      <= FLUSH;
                        idx        <= '0;
                        flush_pend <= 1'b0;
                    end else if (push) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_nxt == 2'd0) begin
                        if (flush_pend) begin
                            state      <= FLUSH;
                            idx        <= '0;
                            flush_pend <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                FLUSH: begin
                    tbl[idx]      <= 1'b0;
                    upd_valid_r   <= 1'b1;
                    upd_addr_r    <= idx;
                    upd_outcome_r <= 1'b0;
                    upd_miss_r    <= 1'b1;
                    idx           <= idx + 1'b1;
                    if (&idx) begin
                        state        <= IDLE;
                        flush_done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.predict     = predict_c;
    assign bus.res_ready   = ready_c;
    assign bus.upd_valid   = upd_valid_r;
    assign bus.upd_addr    = upd_addr_r;
    assign bus.upd_outcome = upd_outcome_r;
    assign bus.upd_miss    = upd_miss_r;
    assign bus.flush_busy  = (state == FLUSH);
    assign bus.flush_done  = flush_done_r;
    assign bus.miss_count  = miss_count_r;
endmodule

// File: tb/tb_bp_update_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_update_ctrl
// Self-checking bench for bp_update_ctrl. Expected update-bus beats are queued
// when results or flushes are issued and popped by a monitor whenever the DUT
// presents UPD_VALID. A second instance with a 2-bit miss counter exercises
// counter saturation.
// ---------------------------------------------------------------------------
module tb_bp_update_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic mon_en = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bp_update_ctrl_if #(.IDX_W(3), .CNT_W(16)) bus ();
    bp_update_ctrl_if #(.IDX_W(3), .CNT_W(2))  bus2 ();

    bp_update_ctrl #(.IDX_W(3), .QDEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    bp_update_ctrl #(.IDX_W(3), .QDEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2)
    );

    typedef struct packed {
        logic [2:0] addr;
        logic       out;
        logic       miss;
    } upd_t;

    typedef struct {
        logic [2:0] addr;
        logic       out;
        logic       miss;
        logic       byp;
        logic       settled;
    } vec_t;

    upd_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_upd(input logic [2:0] a, input logic o, input logic m);
        upd_t e;
        e.addr = a;
        e.out  = o;
        e.miss = m;
        sb.push_back(e);
    endtask

    // Start at/just after a negedge; returns at the negedge after the accept edge.
    task automatic push_one(input logic [2:0] a, input logic o, input logic m);
        chk("push_ready", bus.res_ready, 1);
        bus.res_valid   = 1'b1;
        bus.res_addr    = a;
        bus.res_outcome = o;
        bus.res_miss    = m;
        expect_upd(a, o, m);
        @(negedge clk);
        bus.res_valid = 1'b0;
    endtask

    task automatic check_pred_all(input string tag, input logic [7:0] exp);
        for (int a = 0; a < 8; a++) begin
            bus.lookup_addr = 3'(a);
            #1;
            chk($sformatf("%s_pred%0d", tag, a), bus.predict, exp[a]);
        end
    endtask

    // Update-bus monitor
    always @(negedge clk) begin
        if (mon_en && reset && bus.upd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL upd_unexpected actual addr=%0d out=%0d miss=%0d required no update",
                         bus.upd_addr, bus.upd_outcome, bus.upd_miss);
            end else begin
                upd_t e;
                e = sb.pop_front();
                chk("upd_addr", bus.upd_addr, e.addr);
                chk("upd_outcome", bus.upd_outcome, e.out);
                chk("upd_miss", bus.upd_miss, e.miss);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[8];
        logic [7:0] mdl;
        int         nmiss;
        logic       done;
        logic       found;
        logic [1:0] exp2;
        logic       sat_miss[6];

        vecs[0] = '{3'd3, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{3'd5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3'd3, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{3'd6, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{3'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{3'd6, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{3'd0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{3'd7, 1'b0, 1'b1, 1'b0, 1'b0};
        sat_miss = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        mdl   = 8'h00;
        nmiss = 0;

        bus.lookup_addr  = '0;
        bus.res_valid    = 1'b0;
        bus.res_addr     = '0;
        bus.res_outcome  = 1'b0;
        bus.res_miss     = 1'b0;
        bus.flush_req    = 1'b0;
        bus2.lookup_addr = '0;
        bus2.res_valid   = 1'b0;
        bus2.res_addr    = '0;
        bus2.res_outcome = 1'b0;
        bus2.res_miss    = 1'b0;
        bus2.flush_req   = 1'b0;

        // Reset
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_upd_valid", bus.upd_valid, 0);
        chk("rst_upd_addr", bus.upd_addr, 0);
        chk("rst_upd_outcome", bus.upd_outcome, 0);
        chk("rst_upd_miss", bus.upd_miss, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        chk("rst_flush_busy", bus.flush_busy, 0);
        chk("rst_miss_count", bus.miss_count, 0);
        chk("rst_res_ready", bus.res_ready, 1);
        check_pred_all("rst", 8'h00);

        // Single results from the vector table
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            push_one(vecs[i].addr, vecs[i].out, vecs[i].miss);
            if (vecs[i].miss) begin
                mdl[vecs[i].addr] = vecs[i].out;
                nmiss++;
            end
            bus.lookup_addr = vecs[i].addr;
            #1;
            chk($sformatf("v%0d_bypass", i), bus.predict, vecs[i].byp);
            chk($sformatf("v%0d_upd_early", i), bus.upd_valid, 0);
            @(negedge clk);
            chk($sformatf("v%0d_upd_valid", i), bus.upd_valid, 1);
            @(negedge clk);
            #1;
            chk($sformatf("v%0d_settled", i), bus.predict, vecs[i].settled);
            chk($sformatf("v%0d_upd_end", i), bus.upd_valid, 0);
        end
        chk("vec_miss_count", bus.miss_count, nmiss);
        check_pred_all("vec", mdl);
        chk("vec_sb_empty", sb.size(), 0);

        // Bypass ordering: two mispredictions to the same index
        @(negedge clk);
        chk("ord_ready0", bus.res_ready, 1);
        bus.res_valid = 1'b1; bus.res_addr = 3'd2; bus.res_outcome = 1'b1; bus.res_miss = 1'b1;
        expect_upd(3'd2, 1'b1, 1'b1);
        @(negedge clk);
        bus.lookup_addr = 3'd2;
        #1;
        chk("ord_pred_first", bus.predict, 1);
        chk("ord_ready1", bus.res_ready, 1);
        bus.res_outcome = 1'b0;
        expect_upd(3'd2, 1'b0, 1'b1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        #1;
        chk("ord_pred_young", bus.predict, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("ord_pred_final", bus.predict, 0);
        mdl[2] = 1'b0;
        nmiss += 2;
        chk("ord_sb_empty", sb.size(), 0);

        // Fill the table with ones at one result per cycle
        @(negedge clk);
        bus.res_valid = 1'b1;
        for (int a = 0; a < 8; a++) begin
            bus.res_addr = 3'(a); bus.res_outcome = 1'b1; bus.res_miss = 1'b1;
            chk($sformatf("fill_ready%0d", a), bus.res_ready, 1);
            expect_upd(3'(a), 1'b1, 1'b1);
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        nmiss += 8;
        mdl = 8'hFF;
        repeat (3) @(negedge clk);
        check_pred_all("fill", mdl);
        chk("fill_miss_count", bus.miss_count, nmiss);

        // Flush with one result pending
        @(negedge clk);
        chk("fq_ready", bus.res_ready, 1);
        bus.res_valid = 1'b1; bus.res_addr = 3'd4; bus.res_outcome = 1'b0; bus.res_miss = 1'b1;
        bus.flush_req = 1'b1;
        expect_upd(3'd4, 1'b0, 1'b1);
        for (int a = 0; a < 8; a++) expect_upd(3'(a), 1'b0, 1'b1);
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.flush_req = 1'b0;
        nmiss++;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (bus.flush_done) begin
                done = 1'b1;
            end else begin
                chk("flush_ready_low", bus.res_ready, 0);
                @(negedge clk);
            end
        end
        chk("flush_done_seen", done, 1);
        @(negedge clk);
        chk("flush_done_pulse", bus.flush_done, 0);
        chk("flush_busy_end", bus.flush_busy, 0);
        chk("flush_ready_end", bus.res_ready, 1);
        chk("flush_sb_empty", sb.size(), 0);
        chk("flush_miss_count", bus.miss_count, nmiss);
        mdl = 8'h00;
        check_pred_all("flush", mdl);

        // Reset in the middle of a flush
        @(negedge clk);
        push_one(3'd5, 1'b1, 1'b1);
        push_one(3'd6, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        bus.flush_req = 1'b1;
        for (int a = 0; a < 8; a++) expect_upd(3'(a), 1'b0, 1'b1);
        @(negedge clk);
        bus.flush_req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (bus.flush_busy && bus.upd_valid && bus.upd_addr == 3'd3) found = 1'b1;
        end
        chk("midflush_idx4_seen", found, 1);
        #1;
        mon_en = 1'b0;
        sb.delete();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;
        #1;
        chk("mr_flush_busy", bus.flush_busy, 0);
        chk("mr_upd_valid", bus.upd_valid, 0);
        chk("mr_ready", bus.res_ready, 1);
        chk("mr_miss_count", bus.miss_count, 0);
        check_pred_all("mr", 8'h00);
        repeat (12) @(negedge clk);
        chk("mr_stay_idle", bus.flush_busy, 0);
        chk("mr_done_low", bus.flush_done, 0);

        // Miss counter saturation on the 2-bit counter instance
        @(negedge clk);
        exp2 = 2'd0;
        bus2.res_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus2.res_addr = 3'(i);
            bus2.res_outcome = 1'b1;
            bus2.res_miss = sat_miss[i];
            chk($sformatf("sat_ready%0d", i), bus2.res_ready, 1);
            if (sat_miss[i] && exp2 != 2'd3) exp2 = exp2 + 2'd1;
            @(negedge clk);
            chk($sformatf("sat_count%0d", i), bus2.miss_count, exp2);
        end
        bus2.res_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sat_hold", bus2.miss_count, 3);

        chk("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
